// File: rtl/edge_counter_mc.sv
// edge_counter_mc: per-channel synchronised edge counter with capture/ack.
// Optional build macro EDGE_CNT_SAT_EN: counters saturate instead of wrap.
module edge_counter_mc #(
    parameter int CH          = 4,
    parameter int W           = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE        = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   sig_in,
    input  logic [CH-1:0]   enb,
    input  logic [CH-1:0]   cap_ack,
    output logic [CH*W-1:0] cnt,
    output logic [CH*W-1:0] cap,
    output logic [CH-1:0]   cap_valid,
    output logic [CH-1:0]   cap_ovf,
    output logic [CH-1:0]   cap_ovr,
    output logic [CH-1:0]   ovf
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    genvar i;
    for (i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   hist_q;
        logic                   enb_d;
        logic                   pulse;
        logic                   closing;
        logic [W-1:0]           cnt_q;
        logic [W-1:0]           cap_q;
        logic                   ovf_q;
        logic                   cap_valid_q;
        logic                   cap_ovf_q;
        logic                   cap_ovr_q;

        // synchroniser chain, edge history flop and delayed enable
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                hist_q <= 1'b0;
                enb_d  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
                hist_q <= sync_q[SYNC_STAGES-1];
                enb_d  <= enb[i];
            end
        end

        if (EDGE == 1) begin : g_fall
            assign pulse = ~sync_q[SYNC_STAGES-1] & hist_q;
        end else if (EDGE == 2) begin : g_both
            assign pulse = sync_q[SYNC_STAGES-1] ^ hist_q;
        end else begin : g_rise
            assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;
        end

        assign closing = enb_d & ~enb[i];

        // live count and window overflow flag; cleared whenever enable is low
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (!enb[i]) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (pulse) begin
                if (&cnt_q) begin
                    ovf_q <= 1'b1;
`ifdef EDGE_CNT_SAT_EN
                    cnt_q <= cnt_q;
`else
                    cnt_q <= '0;
`endif
                end else begin
                    cnt_q <= cnt_q + ONE;
                end
            end
        end

        // capture on falling enable; a new capture beats a same-cycle ack
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cap_q       <= '0;
                cap_valid_q <= 1'b0;
                cap_ovf_q   <= 1'b0;
                cap_ovr_q   <= 1'b0;
            end else if (closing) begin
                cap_q       <= cnt_q;
                cap_ovf_q   <= ovf_q;
                cap_valid_q <= 1'b1;
                if (cap_valid_q && !cap_ack[i]) begin
                    cap_ovr_q <= 1'b1;
                end
            end else if (cap_ack[i]) begin
                cap_valid_q <= 1'b0;
            end
        end

        assign cnt[i*W +: W] = cnt_q;
        assign cap[i*W +: W] = cap_q;
        assign cap_valid[i]  = cap_valid_q;
        assign cap_ovf[i]    = cap_ovf_q;
        assign cap_ovr[i]    = cap_ovr_q;
        assign ovf[i]        = ovf_q;
    end

endmodule

// File: tb/tb_edge_counter_mc.sv
// tb_edge_counter_mc: three parameterisations driven with shared stimulus,
// checked each cycle against a window-level edge-count model.
module tb_edge_counter_mc;
    localparam int WD [3] = '{12, 4, 12};
    localparam int ED [3] = '{0, 2, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] sig_in = '0;
    logic [3:0] enb = '0;
    logic [3:0] cap_ack = '0;

    logic [47:0] cnt0, cap0, cnt2, cap2;
    logic [15:0] cnt1, cap1;
    logic [3:0] cv [3];
    logic [3:0] co [3];
    logic [3:0] cr [3];
    logic [3:0] ov [3];

    int total = 0;
    int bad = 0;
    bit running = 1'b1;

    // model: n = edges counted in the open window
    int n    [3][4];
    int mcap [3][4];
    bit mcv  [3][4];
    bit mco  [3][4];
    bit mcr  [3][4];
    bit enbp [3][4];
    bit sh   [4][3];

    always #5 clk = ~clk;

    edge_counter_mc #(.CH(4), .W(12), .SYNC_STAGES(2), .EDGE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enb(enb),
        .cap_ack(cap_ack), .cnt(cnt0), .cap(cap0), .cap_valid(cv[0]),
        .cap_ovf(co[0]), .cap_ovr(cr[0]), .ovf(ov[0])
    );
    edge_counter_mc #(.CH(4), .W(4), .SYNC_STAGES(2), .EDGE(2)) u1 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enb(enb),
        .cap_ack(cap_ack), .cnt(cnt1), .cap(cap1), .cap_valid(cv[1]),
        .cap_ovf(co[1]), .cap_ovr(cr[1]), .ovf(ov[1])
    );
    edge_counter_mc #(.CH(4), .W(12), .SYNC_STAGES(2), .EDGE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enb(enb),
        .cap_ack(cap_ack), .cnt(cnt2), .cap(cap2), .cap_valid(cv[2]),
        .cap_ovf(co[2]), .cap_ovr(cr[2]), .ovf(ov[2])
    );

    function automatic int ecnt(int d, int nn);
        int m = (1 << WD[d]) - 1;
`ifdef EDGE_CNT_SAT_EN
        return (nn > m) ? m : nn;
`else
        return nn % (m + 1);
`endif
    endfunction

    function automatic int eovf(int d, int nn);
        return (nn > (1 << WD[d]) - 1) ? 1 : 0;
    endfunction

    // k: 0 cnt, 1 cap, 2 cap_valid, 3 cap_ovf, 4 cap_ovr, 5 ovf
    function automatic int act(int d, int c, int k);
        logic [11:0] v;
        v = '0;
        case (d)
            0: begin
                if (k == 0) v = cnt0[c*12 +: 12];
                if (k == 1) v = cap0[c*12 +: 12];
            end
            1: begin
                if (k == 0) v[3:0] = cnt1[c*4 +: 4];
                if (k == 1) v[3:0] = cap1[c*4 +: 4];
            end
            default: begin
                if (k == 0) v = cnt2[c*12 +: 12];
                if (k == 1) v = cap2[c*12 +: 12];
            end
        endcase
        if (k == 2) v[0] = cv[d][c];
        if (k == 3) v[0] = co[d][c];
        if (k == 4) v[0] = cr[d][c];
        if (k == 5) v[0] = ov[d][c];
        return {20'b0, v};
    endfunction

    task automatic chk(string nm, int d, int c, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s u%0d ch%0d got=%0d want=%0d", nm, d, c, a, e);
        end
    endtask

    task automatic lit(string nm, int d, int c, int k, int e);
        chk(nm, d, c, act(d, c, k), e);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                n[d][c] = 0; mcap[d][c] = 0; mcv[d][c] = 0;
                mco[d][c] = 0; mcr[d][c] = 0; enbp[d][c] = 0;
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 3; j++) sh[c][j] = 0;
        end
    endtask

    // sh[c][0] is the sample from the previous edge; the edge seen now
    // compares samples taken two and three edges ago
    task automatic model_step();
        bit s, h, p, fall;
        for (int c = 0; c < 4; c++) begin
            s = sh[c][1];
            h = sh[c][2];
            for (int d = 0; d < 3; d++) begin
                case (ED[d])
                    0: p = s & !h;
                    1: p = !s & h;
                    default: p = s ^ h;
                endcase
                fall = enbp[d][c] && !enb[c];
                if (fall) begin
                    if (mcv[d][c] && !cap_ack[c]) mcr[d][c] = 1;
                    mcap[d][c] = ecnt(d, n[d][c]);
                    mco[d][c] = eovf(d, n[d][c]) != 0;
                    mcv[d][c] = 1;
                end else if (cap_ack[c]) begin
                    mcv[d][c] = 0;
                end
                if (!enb[c]) n[d][c] = 0;
                else if (p) n[d][c]++;
                enbp[d][c] = enb[c];
            end
            sh[c][2] = sh[c][1];
            sh[c][1] = sh[c][0];
            sh[c][0] = sig_in[c];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                for (int d = 0; d < 3; d++) begin
                    for (int c = 0; c < 4; c++) begin
                        chk("cnt", d, c, act(d, c, 0), ecnt(d, n[d][c]));
                        chk("ovf", d, c, act(d, c, 5), eovf(d, n[d][c]));
                        chk("cap", d, c, act(d, c, 1), mcap[d][c]);
                        chk("cap_valid", d, c, act(d, c, 2), int'(mcv[d][c]));
                        chk("cap_ovf", d, c, act(d, c, 3), int'(mco[d][c]));
                        chk("cap_ovr", d, c, act(d, c, 4), int'(mcr[d][c]));
                    end
                end
            end
        end
    end

    task automatic tick(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulses(int c, int k, int hi, int lo);
        repeat (k) begin
            sig_in[c] = 1'b1;
            tick(hi);
            sig_in[c] = 1'b0;
            tick(lo);
        end
    endtask

    initial begin
        tick(3);
        lit("rst_cnt", 0, 0, 0, 0);
        lit("rst_cv", 0, 0, 2, 0);
        rst_n = 1'b1;
        tick(2);

        // five rises on channel 0, then close the window
        enb[0] = 1'b1;
        tick(1);
        pulses(0, 5, 3, 3);
        tick(4);
        lit("rise5", 0, 0, 0, 5);
        lit("both10", 1, 0, 0, 10);
        lit("fall5", 2, 0, 0, 5);
        enb[0] = 1'b0;
        tick(1);
        lit("cap5", 0, 0, 1, 5);
        lit("cv5", 0, 0, 2, 1);
        lit("clr", 0, 0, 0, 0);
        lit("oth_cv", 0, 1, 2, 0);
        lit("oth_cnt", 0, 1, 0, 0);

        cap_ack[0] = 1'b1;
        tick(1);
        cap_ack[0] = 1'b0;
        lit("ack", 0, 0, 2, 0);

        // latency: rise first sampled at edge N counts at N+2
        enb[1] = 1'b1;
        tick(2);
        sig_in[1] = 1'b1;
        tick(1);
        lit("lat_n", 0, 1, 0, 0);
        tick(1);
        lit("lat_n1", 0, 1, 0, 0);
        tick(1);
        lit("lat_n2", 0, 1, 0, 1);
        tick(2);
        sig_in[1] = 1'b0;
        tick(4);

        // edge modes with three pulses
        enb[2] = 1'b1;
        tick(1);
        pulses(2, 3, 2, 2);
        tick(4);
        lit("mode_r", 0, 2, 0, 3);
        lit("mode_b", 1, 2, 0, 6);
        lit("mode_f", 2, 2, 0, 3);

        // overflow: 17 edges into the 4-bit both-edge counter
        enb[3] = 1'b1;
        tick(1);
        repeat (17) begin
            sig_in[3] = ~sig_in[3];
            tick(2);
        end
        tick(4);
`ifdef EDGE_CNT_SAT_EN
        lit("ovf_cnt", 1, 3, 0, 15);
`else
        lit("ovf_cnt", 1, 3, 0, 1);
`endif
        lit("ovf_flag", 1, 3, 5, 1);
        lit("ovf_r9", 0, 3, 0, 9);
        enb[3] = 1'b0;
        tick(1);
`ifdef EDGE_CNT_SAT_EN
        lit("ovf_cap", 1, 3, 1, 15);
`else
        lit("ovf_cap", 1, 3, 1, 1);
`endif
        lit("ovf_capf", 1, 3, 3, 1);
        lit("ovf_clr", 1, 3, 5, 0);
        sig_in[3] = 1'b0;
        tick(4);

        // overwrite without ack
        enb[0] = 1'b1;
        tick(1);
        pulses(0, 3, 2, 2);
        tick(4);
        enb[0] = 1'b0;
        tick(1);
        lit("cap3", 0, 0, 1, 3);
        lit("ovr0", 0, 0, 4, 0);
        enb[0] = 1'b1;
        tick(1);
        pulses(0, 4, 2, 2);
        tick(4);
        enb[0] = 1'b0;
        tick(1);
        lit("cap4", 0, 0, 1, 4);
        lit("ovr1", 0, 0, 4, 1);

        // capture with same-cycle ack on channel 2
        enb[2] = 1'b0;
        tick(1);
        lit("c2cap3", 0, 2, 1, 3);
        enb[2] = 1'b1;
        tick(1);
        pulses(2, 2, 2, 2);
        tick(4);
        enb[2] = 1'b0;
        cap_ack[2] = 1'b1;
        tick(1);
        cap_ack[2] = 1'b0;
        lit("sim_cap", 0, 2, 1, 2);
        lit("sim_cv", 0, 2, 2, 1);
        lit("sim_ovr", 0, 2, 4, 0);
        cap_ack[2] = 1'b1;
        tick(1);
        cap_ack[2] = 1'b0;
        lit("ack2", 0, 2, 2, 0);
        lit("hold2", 0, 2, 1, 2);

        // one-cycle enable low, then edge coincident with window close
        enb[1] = 1'b0;
        tick(1);
        enb[1] = 1'b1;
        lit("restart", 0, 1, 0, 0);
        lit("cap1", 0, 1, 1, 1);
        pulses(1, 9, 2, 2);
        sig_in[1] = 1'b1;
        tick(2);
        enb[1] = 1'b0;
        tick(1);
        lit("bnd_cap", 0, 1, 1, 9);
        lit("bnd_cnt", 0, 1, 0, 0);
        enb[1] = 1'b1;
        sig_in[1] = 1'b0;
        tick(6);
        lit("bnd_new", 0, 1, 0, 0);

        // reset in the middle of a window
        enb[0] = 1'b1;
        tick(1);
        pulses(0, 7, 2, 2);
        tick(4);
        lit("pre_rst", 0, 0, 0, 7);
        enb[2] = 1'b1;
        sig_in[2] = 1'b1;
        rst_n = 1'b0;
        #1;
        lit("mid_cnt", 0, 0, 0, 0);
        lit("mid_ovr", 0, 0, 4, 0);
        lit("mid_cap", 0, 1, 1, 0);
        lit("mid_cv", 0, 1, 2, 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        lit("post_cnt", 0, 0, 0, 0);
        lit("post_cv", 0, 0, 2, 0);
        lit("hi_r", 0, 2, 0, 1);
        lit("hi_b", 1, 2, 0, 1);
        lit("hi_f", 2, 2, 0, 0);

        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
